div_sweep_ctrl: RTL and testbench
=================================

DIV_SWEEP_CTRL -- requirements
Module: div_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, width of the dwell count.
REQ-002 SHALL have port UP  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port preset  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-005 SHALL have port abort  input  1  terminate the sweep, return to IDLE.
REQ-006 SHALL have port start_val  input  8  first divider preset value.
REQ-007 SHALL have port stop_val  input  8  last divider preset value.
REQ-008 SHALL have port step_val  input  8  preset increment per step; 0 treated as 1.
REQ-009 SHALL have port dwell  input  DWELL_W  divider output pulses per step; 0 treated as 1.
REQ-010 SHALL have port loop  input  1  1 = restart at start_val after stop_val, never finish.
REQ-011 SHALL have port div_out  input  1  divider terminal-count output, same clock domain.
REQ-012 SHALL have port div_data  output  8  preset value driven to the divider's 8 data inputs.
REQ-013 SHALL have port div_ld_n  output  1  active-low load strobe to the divider preset.
REQ-014 SHALL have port busy  output  1  high while the sweep is active.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal sweep completion.
REQ-016 SHALL have port step_cnt  output  8  number of steps completed in the current pass; wraps mod 256.

Function
REQ-017 SHALL implement states IDLE, LOAD, RUN, NEXT, DONE.
REQ-018 IDLE: start=1 SHALL latch start_val, stop_val, step_val, dwell, loop into internal registers; next state LOAD; start ignored in all other states.
REQ-019 Input changes after latching SHALL NOT affect the running sweep.
REQ-020 LOAD: div_ld_n=0 for exactly one cycle, div_data=current value; next state RUN; start-to-load latency one cycle (start in cycle N, div_ld_n low in cycle N+1).
REQ-021 div_data SHALL hold the current value in every state except IDLE, where it holds its last value.
REQ-022 RUN: rising edges of div_out (registered edge detect, div_out=1 and previous=0) SHALL increment a pulse counter; when counter reaches effective dwell, next state NEXT and counter clears.
REQ-023 An div_out edge in the LOAD cycle SHALL NOT be counted; the edge detector history SHALL be updated every cycle.
REQ-024 NEXT: step_cnt increments; if current==stop or current+step (9-bit sum) > stop or sum>255 -> end of pass; else current += step, next state LOAD.
REQ-025 End of pass with loop=1: current=start, step_cnt=0, next state LOAD; with loop=0: next state DONE.
REQ-026 start_val > stop_val SHALL yield exactly one step at start_val, then end of pass.
REQ-027 DONE: done=1 for one cycle; next state IDLE.
REQ-028 busy SHALL be 1 in LOAD, RUN, NEXT; 0 in IDLE and DONE.
REQ-029 abort SHALL have priority over all transitions: next state IDLE from any state, div_ld_n=1, no done pulse, step_cnt holds.
REQ-030 abort and start in the same IDLE cycle: abort wins, state stays IDLE.

Reset
REQ-031 preset=0 SHALL immediately force state IDLE, div_data=0, div_ld_n=1, busy=0, done=0, step_cnt=0, pulse counter and edge history 0.
REQ-032 preset asserted mid-sweep SHALL abandon the sweep without a done pulse; after release, block waits for start.

Verification
REQ-033 start_val=10, stop_val=30, step_val=10, dwell=2, loop=0 -> loads 10,20,30 each held for 2 div_out edges, then one done pulse, step_cnt=3, busy=0.
REQ-034 start_val=250, stop_val=255, step_val=4 -> loads 250,254 only (258 overflow ends pass), done after second step.
REQ-035 loop=1, start_val=5, stop_val=7, step_val=1, dwell=1 -> load sequence 5,6,7,5,6,... with step_cnt resetting to 0 at each wrap; no done.
REQ-036 step_val=0, dwell=0, start_val=1, stop_val=3 -> treated as step 1, dwell 1: loads 1,2,3, done.
REQ-037 abort asserted in RUN of second step -> IDLE next cycle, busy=0, no done; new start then restarts from latched new start_val.
REQ-038 preset pulsed low during RUN -> all outputs at reset values asynchronously; start with start_val=40, stop_val=40 after release -> single load of 40, done.

Source files
------------

// File: rtl/div_sweep_ctrl.sv
// Programmable divider sweep controller: walks a preset value from start to stop,
// loading the divider and dwelling a fixed number of its output pulses per step.
module div_sweep_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               UP,
    input  logic               preset,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         start_val,
    input  logic [7:0]         stop_val,
    input  logic [7:0]         step_val,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               loop,
    input  logic               div_out,
    output logic [7:0]         div_data,
    output logic               div_ld_n,
    output logic               busy,
    output logic               done,
    output logic [7:0]         step_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         start_q, start_d;
    logic [7:0]         stop_q, stop_d;
    logic [7:0]         step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               loop_q, loop_d;
    logic [7:0]         cur_q, cur_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [DWELL_W-1:0] pcnt_q, pcnt_d;
    logic               prev_q;
    logic               ld_n_q;
    logic               busy_q;
    logic               done_q;

    logic               edge_w;
    logic [8:0]         sum_w;
    logic               pass_end_w;

    assign edge_w     = div_out & ~prev_q;
    assign sum_w      = {1'b0, cur_q} + {1'b0, step_q};
    // sum_w[8] already exceeds any 8-bit stop, but keep it explicit
    assign pass_end_w = (cur_q == stop_q) || (sum_w > {1'b0, stop_q}) || sum_w[8];

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        loop_d  = loop_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        if (abort) begin
            state_d = IDLE;
            pcnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        start_d = start_val;
                        stop_d  = stop_val;
                        step_d  = (step_val == 8'd0) ? 8'd1 : step_val;
                        dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
                        loop_d  = loop;
                        cur_d   = start_val;
                        cnt_d   = 8'd0;
                        pcnt_d  = '0;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    pcnt_d  = '0;
                    state_d = RUN;
                end
                RUN: begin
                    if (edge_w) begin
                        if (pcnt_q + DWELL_W'(1) == dwell_q) begin
                            pcnt_d  = '0;
                            state_d = NEXT;
                        end else begin
                            pcnt_d = pcnt_q + DWELL_W'(1);
                        end
                    end
                end
                NEXT: begin
                    cnt_d = cnt_q + 8'd1;
                    if (!pass_end_w) begin
                        cur_d   = sum_w[7:0];
                        state_d = LOAD;
                    end else if (loop_q) begin
                        cur_d   = start_q;
                        cnt_d   = 8'd0;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge UP or negedge preset) begin
        if (!preset) begin
            state_q <= IDLE;
            start_q <= 8'd0;
            stop_q  <= 8'd0;
            step_q  <= 8'd1;
            dwell_q <= DWELL_W'(1);
            loop_q  <= 1'b0;
            cur_q   <= 8'd0;
            cnt_q   <= 8'd0;
            pcnt_q  <= '0;
            prev_q  <= 1'b0;
            ld_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            loop_q  <= loop_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            prev_q  <= div_out;
            ld_n_q  <= (state_d != LOAD);
            busy_q  <= (state_d == LOAD) || (state_d == RUN) || (state_d == NEXT);
            done_q  <= (state_d == DONE);
        end
    end

    assign div_data = cur_q;
    assign div_ld_n = ld_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_div_sweep_ctrl.sv
// Directed bench for div_sweep_ctrl: load sequences, dwell, loop, abort, reset.
module tb_div_sweep_ctrl;

    logic       UP = 1'b0;
    logic       preset;
    logic       start;
    logic       abort;
    logic [7:0] start_val;
    logic [7:0] stop_val;
    logic [7:0] step_val;
    logic [7:0] dwell;
    logic       loop;
    logic       div_out;
    logic [7:0] div_data;
    logic       div_ld_n;
    logic       busy;
    logic       done;
    logic [7:0] step_cnt;

    int checks = 0;
    int failures = 0;
    logic [18:0] obs;
    logic [18:0] exp_v;

    div_sweep_ctrl #(.DWELL_W(8)) dut (
        .UP(UP), .preset(preset), .start(start), .abort(abort),
        .start_val(start_val), .stop_val(stop_val), .step_val(step_val),
        .dwell(dwell), .loop(loop), .div_out(div_out),
        .div_data(div_data), .div_ld_n(div_ld_n), .busy(busy),
        .done(done), .step_cnt(step_cnt)
    );

    always #5 UP = ~UP;

    // {busy, done, div_ld_n, div_data, step_cnt}
    always_comb obs = {busy, done, div_ld_n, div_data, step_cnt};

    task automatic tick();
        @(posedge UP);
        #1;
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            div_out = 1'b1;
            tick();
            div_out = 1'b0;
            tick();
        end
    endtask

    task automatic run_step(input int n);
        tick();
        pulses(n);
    endtask

    task automatic cfg(input logic [7:0] s, input logic [7:0] e,
                       input logic [7:0] st, input logic [7:0] d,
                       input logic lp);
        start_val = s;
        stop_val  = e;
        step_val  = st;
        dwell     = d;
        loop      = lp;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b0; start = 0; abort = 0; div_out = 0;
        cfg(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        #12;
        exp_v = {1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset obs=%h exp=%h", obs, exp_v);
        end
        @(negedge UP);
        preset = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_idle obs=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_basic();
        cfg(8'd10, 8'd30, 8'd10, 8'd2, 1'b0);
        go();
        cfg(8'd99, 8'd200, 8'd1, 8'd5, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b0, 8'd10, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL basic_load10 obs=%h exp=%h", obs, exp_v);
        end
        div_out = 1'b1;
        tick();
        div_out = 1'b0;
        tick();
        pulses(1);
        exp_v = {1'b1, 1'b0, 1'b1, 8'd10, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL basic_dwell_hold obs=%h exp=%h", obs, exp_v);
        end
        pulses(1);
        exp_v = {1'b1, 1'b0, 1'b0, 8'd20, 8'd1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL basic_load20 obs=%h exp=%h", obs, exp_v);
        end
        run_step(2);
        exp_v = {1'b1, 1'b0, 1'b0, 8'd30, 8'd2};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL basic_load30 obs=%h exp=%h", obs, exp_v);
        end
        run_step(2);
        exp_v = {1'b0, 1'b1, 1'b1, 8'd30, 8'd3};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL basic_done obs=%h exp=%h", obs, exp_v);
        end
        tick();
        exp_v = {1'b0, 1'b0, 1'b1, 8'd30, 8'd3};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL basic_idle obs=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_overflow();
        cfg(8'd250, 8'd255, 8'd4, 8'd1, 1'b0);
        go();
        exp_v = {1'b1, 1'b0, 1'b0, 8'd250, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL ovf_load250 obs=%h exp=%h", obs, exp_v);
        end
        run_step(1);
        exp_v = {1'b1, 1'b0, 1'b0, 8'd254, 8'd1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL ovf_load254 obs=%h exp=%h", obs, exp_v);
        end
        run_step(1);
        exp_v = {1'b0, 1'b1, 1'b1, 8'd254, 8'd2};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL ovf_done obs=%h exp=%h", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_zero_step_dwell();
        logic [7:0] vals [3];
        vals = '{8'd1, 8'd2, 8'd3};
        cfg(8'd1, 8'd3, 8'd0, 8'd0, 1'b0);
        go();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) run_step(1);
            exp_v = {1'b1, 1'b0, 1'b0, vals[i], 8'(i)};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL zero_load%0d obs=%h exp=%h", i, obs, exp_v);
            end
        end
        run_step(1);
        exp_v = {1'b0, 1'b1, 1'b1, 8'd3, 8'd3};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL zero_done obs=%h exp=%h", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_reversed();
        cfg(8'd50, 8'd20, 8'd5, 8'd1, 1'b0);
        go();
        exp_v = {1'b1, 1'b0, 1'b0, 8'd50, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL rev_load obs=%h exp=%h", obs, exp_v);
        end
        run_step(1);
        exp_v = {1'b0, 1'b1, 1'b1, 8'd50, 8'd1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL rev_done obs=%h exp=%h", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_loop();
        logic [7:0] vals [5];
        logic [7:0] cnts [5];
        vals = '{8'd5, 8'd6, 8'd7, 8'd5, 8'd6};
        cnts = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1};
        cfg(8'd5, 8'd7, 8'd1, 8'd1, 1'b1);
        go();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) run_step(1);
            exp_v = {1'b1, 1'b0, 1'b0, vals[i], cnts[i]};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL loop_load%0d obs=%h exp=%h", i, obs, exp_v);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_v = {1'b0, 1'b0, 1'b1, 8'd6, 8'd1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL loop_abort obs=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_abort_start_idle();
        cfg(8'd77, 8'd80, 8'd1, 8'd1, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        exp_v = {1'b0, 1'b0, 1'b1, 8'd6, 8'd1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL abort_start_idle obs=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_abort_run();
        cfg(8'd10, 8'd30, 8'd10, 8'd2, 1'b0);
        go();
        run_step(2);
        exp_v = {1'b1, 1'b0, 1'b0, 8'd20, 8'd1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL abort_pre obs=%h exp=%h", obs, exp_v);
        end
        tick();
        pulses(1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_v = {1'b0, 1'b0, 1'b1, 8'd20, 8'd1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL abort_run obs=%h exp=%h", obs, exp_v);
        end
        pulses(2);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL abort_stays_idle obs=%h exp=%h", obs, exp_v);
        end
        cfg(8'd100, 8'd100, 8'd1, 8'd1, 1'b0);
        go();
        exp_v = {1'b1, 1'b0, 1'b0, 8'd100, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL abort_restart obs=%h exp=%h", obs, exp_v);
        end
        run_step(1);
        exp_v = {1'b0, 1'b1, 1'b1, 8'd100, 8'd1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL abort_restart_done obs=%h exp=%h", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_preset_run();
        cfg(8'd10, 8'd30, 8'd10, 8'd2, 1'b0);
        go();
        tick();
        #2;
        preset = 1'b0;
        #1;
        exp_v = {1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL preset_async obs=%h exp=%h", obs, exp_v);
        end
        tick();
        preset = 1'b1;
        pulses(2);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL preset_wait obs=%h exp=%h", obs, exp_v);
        end
        cfg(8'd40, 8'd40, 8'd1, 8'd1, 1'b0);
        go();
        exp_v = {1'b1, 1'b0, 1'b0, 8'd40, 8'd0};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL preset_load40 obs=%h exp=%h", obs, exp_v);
        end
        run_step(1);
        exp_v = {1'b0, 1'b1, 1'b1, 8'd40, 8'd1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL preset_done obs=%h exp=%h", obs, exp_v);
        end
        tick();
        exp_v = {1'b0, 1'b0, 1'b1, 8'd40, 8'd1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL preset_idle obs=%h exp=%h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_zero_step_dwell();
        test_reversed();
        test_loop();
        test_abort_start_idle();
        test_abort_run();
        test_preset_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
